pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the 5-stage CPU, the generalised replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload plus a control-bit group under a valid/ready handshake, supports synchronous flush (bubble insertion) and back-pressure stalls, and counts stall cycles for performance analysis. One instance sits between each pair of adjacent pipeline stages.

## Interface
Parameters:
- DATA_W, 32, payload width (ALU result, store data, PC+4, instruction, ...)
- CTRL_W, 8, control bit group width (RegWrite, MemtoReg, MemWrite, ...); forced to zero on bubbles
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock, the single clock of the block
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream stage presents a beat
- in_ready  out  1  stage accepts a beat this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- flush  in  1  synchronous kill of all held beats (branch/jump redirect)
- out_valid  out  1  stage holds a valid beat
- out_ready  in  1  downstream stage consumes the beat this cycle
- out_data  out  DATA_W  held payload
- out_ctrl  out  CTRL_W  held control bits; zero whenever out_valid is 0
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Base mode: states EMPTY and FULL, one payload register.
  - in_ready = (state == EMPTY) || out_ready (combinational pass-through of out_ready).
  - EMPTY + in transfer -> FULL. FULL + out transfer, no in transfer -> EMPTY. FULL + both -> FULL with new beat.
- Flush: highest priority. At the edge where flush = 1, state -> EMPTY (all held beats dropped); any beat transferred in that same cycle is discarded. Payload registers need not clear; ctrl registers clear to 0.
- out_ctrl gated: out_ctrl = out_valid ? ctrl_q : 0, so a bubble never asserts a write enable.
- stall_cnt: +1 on every edge where out_valid && !out_ready; holds at 2^CNT_W-1 (saturates, no wrap). Cleared only by rst_n; flush does not affect it.
- Beat order strictly preserved; no beat duplicated or lost except by flush.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, out_valid 0, out_data 0, out_ctrl 0, stall_cnt 0; in_ready 1 once rst_n deasserts (base mode: also 1 during reset).
- Latency: beat accepted at edge N appears on out_* after edge N (visible in cycle N+1), 1 cycle.
- Throughput: 1 beat/cycle when out_ready held high.
- Reset mid-operation discards all beats; first accepted beat after release appears after one edge.

## Configuration
- PIPE_SKID_EN defined: two-entry skid buffer, in_ready registered (no combinational out_ready -> in_ready path).
  - States EMPTY, ONE, TWO; main register drives out_*, skid register holds overflow.
  - in_ready = (state != TWO), from a flop.
  - ONE + in transfer + !out_ready -> TWO (beat into skid). TWO + out_ready -> ONE (skid moves to main); in_ready rises the following cycle. ONE + in and out transfers -> ONE.
  - Flush empties both entries -> EMPTY; reset: in_ready 0 during reset, 1 after release.
- Undefined: base EMPTY/FULL mode as above, combinational in_ready.

## Test plan
- Streaming: out_ready=1, in_valid=1 with in_data 0x10,0x11,0x12 on consecutive cycles -> out_data 0x10,0x11,0x12 one cycle later each, stall_cnt stays 0.
- Stall: hold beat 0xAA with out_ready=0 for 5 cycles -> out_data stays 0xAA, stall_cnt=5; base mode in_ready=0 throughout; skid mode accepts one more beat 0xBB, then in_ready=0; release -> 0xAA then 0xBB.
- Flush: stage FULL with in_ctrl=0xFF, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, new beat discarded.
- Bubble gating: in_valid=0 with in_ctrl=0xFF -> out_ctrl remains 0x00.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15, then holds 15; flush leaves it at 15.
- Async reset mid-stall: drop rst_n between edges -> out_valid, out_ctrl, stall_cnt 0 immediately, before next clk edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, ctrl gating and a saturating stall counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_xfer;
  logic              w_load_main;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY = 2'b00, S_ONE = 2'b01, S_TWO = 2'b10} state_t;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              w_load_skid;
  logic              w_skid_to_main;

  assign in_ready  = r_in_ready;
  assign w_in_xfer = in_valid & r_in_ready;

  // Next-state decode; in_ready is low in TWO, so no input beat arrives there.
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = S_ONE;
            w_load_main = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_in_xfer && out_ready) begin
            w_state_nxt = S_ONE;
            w_load_main = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = S_TWO;
            w_load_skid = 1'b1;
          end else if (out_ready) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_ONE;
          end
        end
        S_TWO: begin
          if (out_ready) begin
            w_state_nxt    = S_ONE;
            w_skid_to_main = 1'b1;
          end else begin
            w_state_nxt = S_TWO;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State and registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  // Main and skid entries; flush clears only the control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= {DATA_W{1'b0}};
      r_ctrl      <= {CTRL_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else if (flush) begin
      r_ctrl      <= {CTRL_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else begin
      if (w_skid_to_main) begin
        r_data <= r_skid_data;
        r_ctrl <= r_skid_ctrl;
      end else if (w_load_main) begin
        r_data <= in_data;
        r_ctrl <= in_ctrl;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end
`else
  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;
  state_t r_state;
  state_t w_state_nxt;

  assign in_ready  = (r_state == S_EMPTY) || out_ready;
  assign w_in_xfer = in_valid & in_ready;

  // Next-state decode; a beat accepted while FULL implies the held one leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = S_FULL;
            w_load_main = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_in_xfer) begin
            w_state_nxt = S_FULL;
            w_load_main = 1'b1;
          end else if (out_ready) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_FULL;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload register; flush clears only the control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {DATA_W{1'b0}};
      r_ctrl <= {CTRL_W{1'b0}};
    end else if (flush) begin
      r_ctrl <= {CTRL_W{1'b0}};
    end else if (w_load_main) begin
      r_data <= in_data;
      r_ctrl <= in_ctrl;
    end
  end
`endif

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_data;
  assign out_ctrl  = out_valid ? r_ctrl : {CTRL_W{1'b0}};
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg in the default (non-skid) build, CNT_W=4.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [3:0]  stall_cnt;

  int total;
  int bad;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic        fl;
    logic        ordy;
    logic        erdy;
    logic        ev;
    logic [31:0] ed;
    logic [7:0]  ec;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] c,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    logic [3:0] exp_cnt;
    total = 0;
    bad   = 0;
    //          iv    data      ctrl   fl    ordy  erdy  ev    edata     ectrl  ecnt
    vecs[0]  = '{1'b1, 32'h10,   8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10,   8'h01, 4'd0};
    vecs[1]  = '{1'b1, 32'h11,   8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11,   8'h02, 4'd0};
    vecs[2]  = '{1'b1, 32'h12,   8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12,   8'h03, 4'd0};
    vecs[3]  = '{1'b0, 32'hFFFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    8'h00, 4'd0};
    vecs[4]  = '{1'b0, 32'hFFFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    8'h00, 4'd0};
    vecs[5]  = '{1'b1, 32'hAA,   8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAA,   8'h5A, 4'd0};
    vecs[6]  = '{1'b1, 32'hBB,   8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,   8'h5A, 4'd1};
    vecs[7]  = '{1'b1, 32'hBB,   8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,   8'h5A, 4'd2};
    vecs[8]  = '{1'b1, 32'hBB,   8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,   8'h5A, 4'd3};
    vecs[9]  = '{1'b1, 32'hBB,   8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,   8'h5A, 4'd4};
    vecs[10] = '{1'b1, 32'hBB,   8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,   8'h5A, 4'd5};
    vecs[11] = '{1'b0, 32'h0,    8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    8'h00, 4'd5};
    vecs[12] = '{1'b1, 32'hC0,   8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC0,   8'hFF, 4'd5};
    vecs[13] = '{1'b1, 32'hC1,   8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    8'h00, 4'd5};
    vecs[14] = '{1'b0, 32'h0,    8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    8'h00, 4'd5};
    vecs[15] = '{1'b1, 32'hD0,   8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD0,   8'h11, 4'd5};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    #5 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].fl, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].erdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_out_data", i), out_data, vecs[i].ed);
      end
      chk($sformatf("v%0d_out_ctrl", i), {24'd0, out_ctrl}, {24'd0, vecs[i].ec});
      chk($sformatf("v%0d_stall_cnt", i), {28'd0, stall_cnt}, {28'd0, vecs[i].ecnt});
    end

    // Saturation: D0 held with out_ready low for 20 edges.
    exp_cnt = 4'd5;
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
      chk($sformatf("sat%0d_stall_cnt", i), {28'd0, stall_cnt}, {28'd0, exp_cnt});
    end
    chk("sat_out_data", out_data, 32'hD0);
    chk("sat_final_15", {28'd0, stall_cnt}, 32'd15);

    // Flush while saturated and stalled.
    drive(1'b1, 32'hD1, 8'hFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("satflush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("satflush_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("satflush_stall_cnt", {28'd0, stall_cnt}, 32'd15);

    // Async reset mid-stall, asserted between edges.
    drive(1'b1, 32'hE5, 8'h77, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("async_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("async_rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'hE0, 8'h44, 1'b0, 1'b1);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_out_data", out_data, 32'hE0);
    chk("post_rst_out_ctrl", {24'd0, out_ctrl}, 32'h44);
    chk("post_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
